// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory responder for the MEM stage of the 5-stage pipeline.
// Performs sized loads/stores on an on-chip word-organised array with a
// configurable number of wait states. Illegal or misaligned requests are
// reported as a one-cycle registered fault and never touch the array.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   mem_en_mem   request valid
//   mem_wr_mem   1 = store, 0 = load
//   funct3_mem   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_mem     byte address
//   wdata_mem    store data
//   stall_mem    combinational stall while an access is outstanding
//   rdata_wb     registered, formatted load data
//   fault_wb     registered one-cycle fault pulse
//
// state  | meaning
// S_IDLE | no access outstanding; a legal request is accepted here
// S_WAIT | counting down wait states; completes when cnt reaches 0

module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_mem,
  input  logic        mem_wr_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wdata_mem,
  output logic        stall_mem,
  output logic [31:0] rdata_wb,
  output logic        fault_wb
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic MEMRW_SEL_WRITE = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          legal;
  logic          complete;
  logic          fault_now;
  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_fmt;
  logic          unused_addr;

  assign idx  = addr_mem[AW+1:2];
  assign lane = addr_mem[1:0];
  // Upper address bits are intentionally ignored so accesses wrap.
  assign unused_addr = ^addr_mem[31:AW+2];

  always_comb begin
    legal = 1'b0;
    case (funct3_mem)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_mem[0];
      3'b010:  legal = (lane == 2'b00);
      3'b100:  legal = (mem_wr_mem != MEMRW_SEL_WRITE);
      3'b101:  legal = (mem_wr_mem != MEMRW_SEL_WRITE) && !addr_mem[0];
      default: legal = 1'b0;
    endcase
  end

  // Completion happens in IDLE only for zero wait states, otherwise at cnt==0 in WAIT.
  always_comb begin
    complete = 1'b0;
    if (mem_en_mem && legal) begin
      if (state == S_IDLE)
        complete = (WAIT_STATES == 0);
      else
        complete = (cnt == 4'd0);
    end
  end

  assign fault_now = mem_en_mem && !legal;
  assign stall_mem = mem_en_mem && legal && !complete;

  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata_mem;
    case (funct3_mem[1:0])
      2'b00: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata_mem[7:0]}};
      end
      2'b01: begin
        be         = addr_mem[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_mem[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = addr_mem[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_fmt = 32'h0;
    case (funct3_mem)
      3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_fmt = rd_word;
      3'b100:  rd_fmt = {24'h0, rd_byte};
      3'b101:  rd_fmt = {16'h0, rd_half};
      default: rd_fmt = 32'h0;
    endcase
  end

  // Array is not reset; write is suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (!rst && complete && mem_wr_mem == MEMRW_SEL_WRITE) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      rdata_wb <= 32'h0;
      fault_wb <= 1'b0;
    end else begin
      fault_wb <= fault_now;
      if (fault_now)
        rdata_wb <= 32'h0;
      else if (complete && mem_wr_mem != MEMRW_SEL_WRITE)
        rdata_wb <= rd_fmt;

      case (state)
        S_IDLE: begin
          if (mem_en_mem && legal && WAIT_STATES != 0) begin
            state <= S_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        S_WAIT: begin
          // Withdrawn, faulting or completing requests all end the access.
          if (!mem_en_mem || !legal || cnt == 4'd0) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        stall0, stall3, stall2;
  logic [31:0] rdata0, rdata3, rdata2;
  logic        fault0, fault3, fault2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_en_mem(en), .mem_wr_mem(wr), .funct3_mem(f3),
    .addr_mem(addr), .wdata_mem(wdata), .stall_mem(stall0), .rdata_wb(rdata0),
    .fault_wb(fault0));

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .mem_en_mem(en), .mem_wr_mem(wr), .funct3_mem(f3),
    .addr_mem(addr), .wdata_mem(wdata), .stall_mem(stall3), .rdata_wb(rdata3),
    .fault_wb(fault3));

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .mem_en_mem(en), .mem_wr_mem(wr), .funct3_mem(f3),
    .addr_mem(addr), .wdata_mem(wdata), .stall_mem(stall2), .rdata_wb(rdata2),
    .fault_wb(fault2));

  typedef struct {
    logic        en;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        fault;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic get_stall(input int sel);
    case (sel)
      3: return stall3;
      2: return stall2;
      default: return stall0;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    case (sel)
      3: return rdata3;
      2: return rdata2;
      default: return rdata0;
    endcase
  endfunction

  // Holds one request for nc cycles; returns just after the completion edge.
  task automatic access(input int sel, input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d, input int nc,
                        input logic chk_hold, input logic [31:0] hold);
    @(negedge clk);
    en = 1'b1; wr = w; f3 = fn; addr = a; wdata = d;
    for (int i = 0; i < nc; i++) begin
      #1;
      chk($sformatf("stall_ws%0d_cyc%0d", sel, i), 32'(get_stall(sel)), 32'(i < nc - 1));
      if (chk_hold)
        chk($sformatf("hold_ws%0d_cyc%0d", sel, i), get_rdata(sel), hold);
      @(posedge clk);
      if (i < nc - 1) @(negedge clk);
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en    wr    f3      addr          wdata         stall rdata         fault
    vecs[0]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 3'b000, 32'h0000_0101, 32'h0000005A, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        1'b0, 32'hDEAD5AEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        1'b0, 32'h000000DE, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        1'b0, 32'hFFFFDEAD, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        1'b0, 32'h00005AEF, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        1'b0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 3'b001, 32'h0000_0101, 32'h00001234, 1'b0, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        1'b0, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        1'b0, 32'hDEAD5AEF, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        1'b0, 32'hDEAD5AEF, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'hCAFEBEEF, 1'b0, 32'hDEAD5AEF, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        1'b0, 32'h0000005A, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        1'b0, 32'hBEEF5AEF, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 3'b010, 32'h0000_1004, 32'h11111111, 1'b0, 32'hBEEF5AEF, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'h0,        1'b0, 32'h11111111, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 3'b100, 32'h0000_0200, 32'h0,        1'b0, 32'h0000_0000, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        1'b0, 32'h0000BEEF, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_stall0", 32'(stall0), 32'h0);
    chk("reset_rdata0", rdata0, 32'h0);
    chk("reset_fault0", 32'(fault0), 32'h0);
    chk("reset_stall3", 32'(stall3), 32'h0);
    chk("reset_rdata3", rdata3, 32'h0);

    // WAIT_STATES=0 table
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      en = vecs[i].en; wr = vecs[i].wr; f3 = vecs[i].f3;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall0), 32'(vecs[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rdata", i), rdata0, vecs[i].rdata);
      chk($sformatf("v%0d_fault", i), 32'(fault0), 32'(vecs[i].fault));
    end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);

    // WAIT_STATES=3: stall 1,1,1,0 and back-to-back acceptance
    access(3, 1'b1, 3'b010, 32'h0000_0180, 32'hA5A5A5A5, 4, 1'b0, 32'h0);
    access(3, 1'b0, 3'b010, 32'h0000_0180, 32'h0, 4, 1'b0, 32'h0);
    chk("ws3_lw1_data", rdata3, 32'hA5A5A5A5);
    access(3, 1'b1, 3'b010, 32'h0000_0180, 32'h5A5A0000, 4, 1'b1, 32'hA5A5A5A5);
    chk("ws3_after_sw_hold", rdata3, 32'hA5A5A5A5);
    access(3, 1'b0, 3'b010, 32'h0000_0180, 32'h0, 4, 1'b1, 32'hA5A5A5A5);
    chk("ws3_lw2_data", rdata3, 32'h5A5A0000);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);

    // WAIT_STATES=2: withdrawn store
    access(2, 1'b1, 3'b010, 32'h0000_0300, 32'h12345678, 3, 1'b0, 32'h0);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; f3 = 3'b010; addr = 32'h0000_0300; wdata = 32'h77777777;
    #1;
    chk("ws2_wd_stall_c0", 32'(stall2), 32'h1);
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("ws2_wd_stall_c1", 32'(stall2), 32'h0);
    @(posedge clk);
    access(2, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 3, 1'b0, 32'h0);
    chk("ws2_after_withdraw", rdata2, 32'h12345678);

    // WAIT_STATES=2: store aborted by reset mid-WAIT
    @(negedge clk);
    en = 1'b1; wr = 1'b1; f3 = 3'b010; addr = 32'h0000_0300; wdata = 32'h99999999;
    #1;
    chk("ws2_rst_stall_c0", 32'(stall2), 32'h1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("ws2_rst_stall_c1", 32'(stall2), 32'h1);
    #1;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("ws2_rst_stall", 32'(stall2), 32'h0);
    chk("ws2_rst_rdata", rdata2, 32'h0);
    chk("ws2_rst_fault", 32'(fault2), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    access(2, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 3, 1'b1, 32'h0);
    chk("ws2_after_rst_abort", rdata2, 32'h12345678);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
